// File: rtl/alu_pkg.sv
// Shared ALU definitions: op-code encoding, response-stage state and the ALU function.
// alu_compute works on 64-bit containers; the xlen argument selects 32- or 64-bit semantics.
package alu_pkg;

    localparam int ALU_OP_W = 4;

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_e;

    typedef enum logic {
        RSP_EMPTY = 1'b0,
        RSP_FULL  = 1'b1
    } rsp_state_e;

    // Unused op codes (10-15) fall through to ADD.
    function automatic logic [63:0] alu_compute(
        input logic [ALU_OP_W-1:0] op,
        input logic [63:0]         a,
        input logic [63:0]         b,
        input int                  xlen
    );
        logic [5:0]  sh;
        logic [63:0] a_sx;
        logic [63:0] b_sx;
        logic [63:0] a_zx;
        logic [63:0] b_zx;
        logic [63:0] res;
        if (xlen == 64) begin
            sh   = b[5:0];
            a_sx = a;
            b_sx = b;
            a_zx = a;
            b_zx = b;
        end else begin
            sh   = {1'b0, b[4:0]};
            a_sx = {{32{a[31]}}, a[31:0]};
            b_sx = {{32{b[31]}}, b[31:0]};
            a_zx = {32'd0, a[31:0]};
            b_zx = {32'd0, b[31:0]};
        end
        case (op)
            ALU_SUB:  res = a - b;
            ALU_SLL:  res = a << sh;
            ALU_SLT:  res = {63'd0, ($signed(a_sx) < $signed(b_sx))};
            ALU_SLTU: res = {63'd0, (a_zx < b_zx)};
            ALU_XOR:  res = a ^ b;
            ALU_SRL:  res = a_zx >> sh;
            ALU_SRA:  res = $signed(a_sx) >>> sh;
            ALU_OR:   res = a | b;
            ALU_AND:  res = a & b;
            default:  res = a + b;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/alu_share_arb_if.sv
// Request/response bundle for the shared ALU: two requesters in, one tagged response out.
// slave is the arbiter side, master is the requester/consumer side.
interface alu_share_arb_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 4
);
    import alu_pkg::*;

    logic                req0_valid;
    logic                req0_ready;
    logic [ALU_OP_W-1:0] req0_alu_op;
    logic [XLEN-1:0]     req0_a;
    logic [XLEN-1:0]     req0_b;
    logic [TAG_W-1:0]    req0_tag;

    logic                req1_valid;
    logic                req1_ready;
    logic [ALU_OP_W-1:0] req1_alu_op;
    logic [XLEN-1:0]     req1_a;
    logic [XLEN-1:0]     req1_b;
    logic [TAG_W-1:0]    req1_tag;

    logic                rsp_valid;
    logic                rsp_ready;
    logic                rsp_id;
    logic [TAG_W-1:0]    rsp_tag;
    logic [XLEN-1:0]     rsp_result;

    modport slave (
        input  req0_valid, req0_alu_op, req0_a, req0_b, req0_tag,
        input  req1_valid, req1_alu_op, req1_a, req1_b, req1_tag,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_tag, rsp_result
    );

    modport master (
        output req0_valid, req0_alu_op, req0_a, req0_b, req0_tag,
        output req1_valid, req1_alu_op, req1_a, req1_b, req1_tag,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_tag, rsp_result
    );

endinterface

// File: rtl/alu_rr_arb2.sv
// Two-way round-robin arbiter; grant is combinational from valid and the registered prio.
// prio moves to the losing side whenever advance (an accepted grant) is asserted.
module alu_rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] valid,
    input  logic       advance,
    output logic       grant,
    output logic       grant_valid
);

    logic prio_q;
    logic prio_d;

    always_comb begin
        grant       = valid[1];
        grant_valid = |valid;
        if (valid == 2'b11) begin
            grant = prio_q;
        end
        prio_d = prio_q;
        if (advance) begin
            prio_d = ~grant;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/alu_share_arb.sv
// Shared-ALU arbiter + one-entry registered response stage; result visible the cycle after accept.
// Backpressure: readies drop when the response register is full and rsp_ready is low; drain+accept is bubble-free.
// Optional ALU_SHARE_ARB_PERF_EN adds saturating grant/conflict counters.
module alu_share_arb
    import alu_pkg::*;
#(
    parameter int XLEN  = 32,  // 32 or 64
    parameter int TAG_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_share_arb_if.slave       bus
`ifdef ALU_SHARE_ARB_PERF_EN
    ,
    output logic [31:0]          perf_grant0,
    output logic [31:0]          perf_grant1,
    output logic [31:0]          perf_conflict
`endif
);

    rsp_state_e          state_q;
    rsp_state_e          state_d;
    logic [XLEN-1:0]     rsp_result_q;
    logic [XLEN-1:0]     rsp_result_d;
    logic                rsp_id_q;
    logic                rsp_id_d;
    logic [TAG_W-1:0]    rsp_tag_q;
    logic [TAG_W-1:0]    rsp_tag_d;

    logic                grant;
    logic                grant_valid;
    logic                can_issue;
    logic                accept;
    logic [ALU_OP_W-1:0] op_sel;
    logic [XLEN-1:0]     a_sel;
    logic [XLEN-1:0]     b_sel;
    logic [TAG_W-1:0]    tag_sel;
    logic [XLEN-1:0]     alu_res;

    alu_rr_arb2 u_arb (
        .clk         (clk),
        .rst_n       (rst_n),
        .valid       ({bus.req1_valid, bus.req0_valid}),
        .advance     (accept),
        .grant       (grant),
        .grant_valid (grant_valid)
    );

    // rst_n gating keeps both readies low during reset even though reset is synchronous.
    assign can_issue      = rst_n && ((state_q == RSP_EMPTY) || bus.rsp_ready);
    assign accept         = can_issue && grant_valid;
    assign bus.req0_ready = accept && !grant;
    assign bus.req1_ready = accept && grant;

    always_comb begin
        op_sel  = bus.req0_alu_op;
        a_sel   = bus.req0_a;
        b_sel   = bus.req0_b;
        tag_sel = bus.req0_tag;
        if (grant) begin
            op_sel  = bus.req1_alu_op;
            a_sel   = bus.req1_a;
            b_sel   = bus.req1_b;
            tag_sel = bus.req1_tag;
        end
    end

    assign alu_res = XLEN'(alu_compute(op_sel, 64'(a_sel), 64'(b_sel), XLEN));

    always_comb begin
        state_d      = state_q;
        rsp_result_d = rsp_result_q;
        rsp_id_d     = rsp_id_q;
        rsp_tag_d    = rsp_tag_q;
        if (accept) begin
            state_d      = RSP_FULL;
            rsp_result_d = alu_res;
            rsp_id_d     = grant;
            rsp_tag_d    = tag_sel;
        end else if (bus.rsp_ready) begin
            state_d = RSP_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= RSP_EMPTY;
            rsp_result_q <= '0;
            rsp_id_q     <= 1'b0;
            rsp_tag_q    <= '0;
        end else begin
            state_q      <= state_d;
            rsp_result_q <= rsp_result_d;
            rsp_id_q     <= rsp_id_d;
            rsp_tag_q    <= rsp_tag_d;
        end
    end

    assign bus.rsp_valid  = (state_q == RSP_FULL);
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_tag    = rsp_tag_q;
    assign bus.rsp_result = rsp_result_q;

`ifdef ALU_SHARE_ARB_PERF_EN
    logic [31:0] perf_g0_q;
    logic [31:0] perf_g0_d;
    logic [31:0] perf_g1_q;
    logic [31:0] perf_g1_d;
    logic [31:0] perf_cf_q;
    logic [31:0] perf_cf_d;

    always_comb begin
        perf_g0_d = perf_g0_q;
        perf_g1_d = perf_g1_q;
        perf_cf_d = perf_cf_q;
        if (bus.req0_ready && perf_g0_q != 32'hFFFF_FFFF) begin
            perf_g0_d = perf_g0_q + 32'd1;
        end
        if (bus.req1_ready && perf_g1_q != 32'hFFFF_FFFF) begin
            perf_g1_d = perf_g1_q + 32'd1;
        end
        if (can_issue && bus.req0_valid && bus.req1_valid && perf_cf_q != 32'hFFFF_FFFF) begin
            perf_cf_d = perf_cf_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_g0_q <= 32'd0;
            perf_g1_q <= 32'd0;
            perf_cf_q <= 32'd0;
        end else begin
            perf_g0_q <= perf_g0_d;
            perf_g1_q <= perf_g1_d;
            perf_cf_q <= perf_cf_d;
        end
    end

    assign perf_grant0   = perf_g0_q;
    assign perf_grant1   = perf_g1_q;
    assign perf_conflict = perf_cf_q;
`endif

endmodule

// File: tb/tb_alu_share_arb.sv
// Randomized + directed bench for alu_share_arb (XLEN=32) with a queue scoreboard and reference model.
// Perf counter checks are compiled in when ALU_SHARE_ARB_PERF_EN is defined.
`timescale 1ns/1ps
module tb_alu_share_arb;
    import alu_pkg::*;

    localparam int XLEN  = 32;
    localparam int TAG_W = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_share_arb_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus();

`ifdef ALU_SHARE_ARB_PERF_EN
    logic [31:0] perf_grant0;
    logic [31:0] perf_grant1;
    logic [31:0] perf_conflict;
`endif

    alu_share_arb #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus)
`ifdef ALU_SHARE_ARB_PERF_EN
        ,
        .perf_grant0   (perf_grant0),
        .perf_grant1   (perf_grant1),
        .perf_conflict (perf_conflict)
`endif
    );

    typedef struct {
        logic        id;
        logic [3:0]  tag;
        logic [31:0] res;
    } rsp_t;

    rsp_t q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Reference ALU from the op-code table, plain 32-bit arithmetic.
    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int sh;
        sh = int'(b % 32);
        case (op)
            4'd1:    return a - b;
            4'd2:    return a << sh;
            4'd3:    return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            4'd4:    return (a < b) ? 32'd1 : 32'd0;
            4'd5:    return a ^ b;
            4'd6:    return a >> sh;
            4'd7:    return 32'(int'(a) >>> sh);
            4'd8:    return a | b;
            4'd9:    return a & b;
            default: return a + b;
        endcase
    endfunction

    // Monitor / scoreboard: model state of the response slot and the round-robin pointer.
    logic full_m = 1'b0;
    logic prio_m = 1'b0;
    logic rst_prev = 1'b1;
    logic mon_can, mon_g, mon_e0, mon_e1;
    rsp_t mon_exp;
    rsp_t mon_new;

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_ready0", 32'(bus.req0_ready), 32'd0);
            chk("rst_ready1", 32'(bus.req1_ready), 32'd0);
            if (!rst_prev) begin
                chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
                chk("rst_rsp_result", bus.rsp_result, 32'd0);
                chk("rst_rsp_tag", 32'(bus.rsp_tag), 32'd0);
                chk("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
            end
            q.delete();
            full_m = 1'b0;
            prio_m = 1'b0;
        end else begin
            if (full_m && q.size() > 0) begin
                mon_exp = q[0];
                chk("rsp_valid", 32'(bus.rsp_valid), 32'd1);
                chk("rsp_id", 32'(bus.rsp_id), 32'(mon_exp.id));
                chk("rsp_tag", 32'(bus.rsp_tag), 32'(mon_exp.tag));
                chk("rsp_result", bus.rsp_result, mon_exp.res);
                if (bus.rsp_ready) void'(q.pop_front());
            end else begin
                chk("rsp_idle", 32'(bus.rsp_valid), 32'd0);
            end
            mon_can = !full_m || bus.rsp_ready;
            mon_g   = (bus.req0_valid && bus.req1_valid) ? prio_m : bus.req1_valid;
            mon_e0  = mon_can && bus.req0_valid && !mon_g;
            mon_e1  = mon_can && bus.req1_valid && mon_g;
            if (bus.req0_valid || bus.req1_valid) begin
                chk("ready0", 32'(bus.req0_ready), 32'(mon_e0));
                chk("ready1", 32'(bus.req1_ready), 32'(mon_e1));
            end
            if (bus.req0_ready && bus.req1_ready) begin
                chk("ready_both", 32'd1, 32'd0);
            end
            if (mon_e0) begin
                mon_new.id  = 1'b0;
                mon_new.tag = bus.req0_tag;
                mon_new.res = ref_alu(bus.req0_alu_op, bus.req0_a, bus.req0_b);
                q.push_back(mon_new);
            end else if (mon_e1) begin
                mon_new.id  = 1'b1;
                mon_new.tag = bus.req1_tag;
                mon_new.res = ref_alu(bus.req1_alu_op, bus.req1_a, bus.req1_b);
                q.push_back(mon_new);
            end
            if (mon_e0 || mon_e1) prio_m = mon_e0;
            full_m = mon_e0 || mon_e1 || (full_m && !bus.rsp_ready);
        end
        rst_prev = rst_n;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive0(input logic v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag);
        bus.req0_valid  = v;
        bus.req0_alu_op = op;
        bus.req0_a      = a;
        bus.req0_b      = b;
        bus.req0_tag    = tag;
    endtask

    task automatic drive1(input logic v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag);
        bus.req1_valid  = v;
        bus.req1_alu_op = op;
        bus.req1_a      = a;
        bus.req1_b      = b;
        bus.req1_tag    = tag;
    endtask

    // Issue one req0 op with rsp_ready high; check the result the cycle after acceptance.
    task automatic single(input string name, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
        bit got;
        got = 1'b0;
        bus.rsp_ready = 1'b1;
        drive1(1'b0, 4'd0, 32'd0, 32'd0, 4'd0);
        drive0(1'b1, op, a, b, 4'd9);
        for (int k = 0; k < 10 && !got; k++) begin
            @(negedge clk);
            if (bus.req0_ready) got = 1'b1;
            step();
        end
        bus.req0_valid = 1'b0;
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: req0 never accepted, expected acceptance within 10 cycles", name);
        end else begin
            @(negedge clk);
            chk(name, bus.rsp_result, exp);
        end
        step();
    endtask

    function automatic logic [31:0] rnd_operand();
        logic [31:0] v;
        case ($urandom_range(0, 5))
            0: v = 32'h0000_0000;
            1: v = 32'hFFFF_FFFF;
            2: v = 32'h8000_0000;
            3: v = 32'h7FFF_FFFF;
            4: v = 32'($urandom_range(0, 70));
            default: v = $urandom;
        endcase
        return v;
    endfunction

`ifdef ALU_SHARE_ARB_PERF_EN
    logic [31:0] p0_s, p1_s, pc_s;
`endif

    initial begin
        // Reset with both requesters presenting the contention pattern.
        bus.rsp_ready = 1'b1;
        drive0(1'b1, 4'd0, 32'd5, 32'd7, 4'd1);
        drive1(1'b1, 4'd1, 32'd5, 32'd7, 4'd2);
        rst_n = 1'b0;
        repeat (3) step();
`ifdef ALU_SHARE_ARB_PERF_EN
        chk("perf_rst_g0", perf_grant0, 32'd0);
        chk("perf_rst_g1", perf_grant1, 32'd0);
        chk("perf_rst_cf", perf_conflict, 32'd0);
`endif
        rst_n = 1'b1;

        // Contention: first grant to req0, then alternate one response per cycle.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 0) begin
                chk("first_grant_req0", 32'(bus.req0_ready), 32'd1);
            end else begin
                chk("cont_valid", 32'(bus.rsp_valid), 32'd1);
                chk("cont_id", 32'(bus.rsp_id), ((i % 2) == 1) ? 32'd0 : 32'd1);
                chk("cont_result", bus.rsp_result, ((i % 2) == 1) ? 32'd12 : 32'hFFFF_FFFE);
            end
            step();
        end

        // Backpressure: SRA held while req1 waits, then req1 accepted as rsp_ready rises.
        drive1(1'b0, 4'd0, 32'd0, 32'd0, 4'd0);
        drive0(1'b1, 4'd7, 32'h8000_0000, 32'd4, 4'd3);
        @(negedge clk);
        chk("bp_accept_sra", 32'(bus.req0_ready), 32'd1);
        step();
        bus.req0_valid = 1'b0;
        bus.rsp_ready  = 1'b0;
        drive1(1'b1, 4'd5, 32'h0F0F_0F0F, 32'hFFFF_0000, 4'd5);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("bp_hold_result", bus.rsp_result, 32'hF800_0000);
            chk("bp_hold_valid", 32'(bus.rsp_valid), 32'd1);
            chk("bp_ready0", 32'(bus.req0_ready), 32'd0);
            chk("bp_ready1", 32'(bus.req1_ready), 32'd0);
            step();
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready1", 32'(bus.req1_ready), 32'd1);
        step();
        bus.req1_valid = 1'b0;
        @(negedge clk);
        chk("bp_new_id", 32'(bus.rsp_id), 32'd1);
        chk("bp_new_result", bus.rsp_result, 32'hF0F0_0F0F);
        step();

        // Compare ops, default op code and shift-amount masking.
        single("slt_neg1_lt_1", 4'd3, 32'hFFFF_FFFF, 32'd1, 32'd1);
        single("sltu_max_lt_1", 4'd4, 32'hFFFF_FFFF, 32'd1, 32'd0);
        single("op12_is_add", 4'd12, 32'd3, 32'd4, 32'd7);
        single("sll_mask_33", 4'd2, 32'd1, 32'd33, 32'd2);

        // Random traffic with a reset pulse in the middle.
        for (int c = 0; c < 1500; c++) begin
            if (c == 700) begin
                rst_n = 1'b0;
                repeat (3) step();
                rst_n = 1'b1;
            end
            drive0($urandom_range(0, 9) < 7, 4'($urandom_range(0, 15)), rnd_operand(), rnd_operand(), 4'($urandom_range(0, 15)));
            drive1($urandom_range(0, 9) < 7, 4'($urandom_range(0, 15)), rnd_operand(), rnd_operand(), 4'($urandom_range(0, 15)));
            bus.rsp_ready = $urandom_range(0, 9) < 6;
            step();
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.rsp_ready  = 1'b1;
        repeat (3) step();
        chk("queue_drained", 32'(q.size()), 32'd0);

`ifdef ALU_SHARE_ARB_PERF_EN
        drive0(1'b1, 4'd0, 32'd1, 32'd2, 4'd1);
        drive1(1'b1, 4'd0, 32'd3, 32'd4, 4'd2);
        p0_s = perf_grant0;
        p1_s = perf_grant1;
        pc_s = perf_conflict;
        repeat (10) step();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        chk("perf_grant0_delta", perf_grant0 - p0_s, 32'd5);
        chk("perf_grant1_delta", perf_grant1 - p1_s, 32'd5);
        chk("perf_conflict_delta", perf_conflict - pc_s, 32'd10);
        repeat (2) step();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion earlier", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
